// File: rtl/semaforo_pkg.sv
// Phase codes and FSM encoding shared by the traffic-light controller and its monitor.
package semaforo_pkg;

  localparam logic [2:0] ROJO          = 3'd0;
  localparam logic [2:0] ROJO_AMARILLO = 3'd1;
  localparam logic [2:0] VERDE         = 3'd2;
  localparam logic [2:0] AMARILLO      = 3'd3;
  localparam logic [2:0] APAGADO       = 3'd4;
  localparam logic [2:0] ILEGAL        = 3'd7;

  typedef enum logic {
    StEspera      = 1'b0,
    StSeguimiento = 1'b1
  } estado_t;

  // Lamp vector is {rojo, amarillo, verde}.
  function automatic logic [2:0] decodificar(input logic [2:0] rav);
    logic [2:0] cod;
    case (rav)
      3'b100:  cod = ROJO;
      3'b110:  cod = ROJO_AMARILLO;
      3'b001:  cod = VERDE;
      3'b010:  cod = AMARILLO;
      3'b000:  cod = APAGADO;
      default: cod = ILEGAL;
    endcase
    return cod;
  endfunction

  // Only legal successor of each lit phase; ILEGAL means no legal successor exists.
  function automatic logic [2:0] siguiente(input logic [2:0] cod);
    logic [2:0] sig;
    case (cod)
      ROJO:          sig = ROJO_AMARILLO;
      ROJO_AMARILLO: sig = VERDE;
      VERDE:         sig = AMARILLO;
      AMARILLO:      sig = ROJO;
      default:       sig = ILEGAL;
    endcase
    return sig;
  endfunction

endpackage

// File: rtl/contador_fase.sv
// Saturating dwell counter: loads 1 when a new phase starts, then counts held cycles.
module contador_fase (
  input  logic        clk,
  input  logic        rst,
  input  logic        reiniciar,
  input  logic        habilitar,
  output logic [23:0] cuenta
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cuenta <= '0;
    end else if (reiniciar) begin
      cuenta <= 24'd1;
    end else if (habilitar && (cuenta != 24'hFFFFFF)) begin
      cuenta <= cuenta + 24'd1;
    end
  end

endmodule

// File: rtl/monitor_semaforo.sv
// Traffic-light sequence monitor: decodes lamps, tracks R->RA->V->A->R, flags sticky errors.
// Phase-duration checking is built only when MONITOR_SEMAFORO_DURACION_EN is defined.
module monitor_semaforo
  import semaforo_pkg::*;
#(
  parameter logic [23:0] DIVISOR    = 24'd500000,
  parameter logic [23:0] TOLERANCIA = 24'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rojo,
  input  logic        amarillo,
  input  logic        verde,
  input  logic        borrar_errores,
  output logic [2:0]  fase,
  output logic        fase_valida,
  output logic        error_codigo,
  output logic        error_secuencia,
  output logic        error_duracion,
  output logic [15:0] ciclos_completos,
  output logic [23:0] duracion_ultima
);

  estado_t     estado_q;
  logic [2:0]  lamp_q;
  logic [2:0]  prev_q;
  logic        err_cod_q;
  logic        err_sec_q;
  logic [15:0] ciclos_q;

  logic [2:0]  cod;
  logic        cambio;
  logic        seguimiento;
  logic        cambio_legal;
  logic        error_seq;
  logic        fin_ciclo;

  assign cod          = decodificar(lamp_q);
  assign cambio       = (cod != prev_q);
  assign seguimiento  = (estado_q == StSeguimiento);
  assign cambio_legal = seguimiento && cambio && (cod != ILEGAL) && (cod == siguiente(prev_q));
  // ILEGAL is reported as a code error only, never as a sequence error.
  assign error_seq    = seguimiento && cambio && (cod != ILEGAL) && !cambio_legal;
  assign fin_ciclo    = cambio_legal && (prev_q == AMARILLO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q  <= StEspera;
      lamp_q    <= 3'b000;
      prev_q    <= APAGADO;
      err_cod_q <= 1'b0;
      err_sec_q <= 1'b0;
      ciclos_q  <= '0;
    end else begin
      lamp_q    <= {rojo, amarillo, verde};
      prev_q    <= cod;
      err_cod_q <= (err_cod_q & ~borrar_errores) | (cod == ILEGAL);
      err_sec_q <= (err_sec_q & ~borrar_errores) | error_seq;
      if (fin_ciclo) begin
        ciclos_q <= ciclos_q + 16'd1;
      end
      case (estado_q)
        StEspera: begin
          if (cambio && (cod == ROJO)) begin
            estado_q <= StSeguimiento;
          end
        end
        StSeguimiento: begin
          if ((cod == ILEGAL) || error_seq) begin
            estado_q <= StEspera;
          end
        end
        default: estado_q <= StEspera;
      endcase
    end
  end

  assign fase             = cod;
  assign fase_valida      = seguimiento;
  assign error_codigo     = err_cod_q;
  assign error_secuencia  = err_sec_q;
  assign ciclos_completos = ciclos_q;

`ifdef MONITOR_SEMAFORO_DURACION_EN
  localparam logic [24:0] LimSup = {1'b0, DIVISOR} + {1'b0, TOLERANCIA};
  localparam logic [24:0] LimInf = (DIVISOR > TOLERANCIA) ? {1'b0, DIVISOR - TOLERANCIA} : '0;

  logic [23:0] cuenta;
  logic [23:0] dur_q;
  logic        medir_q;
  logic        err_dur_q;
  logic        fuera_rango;
  logic        excede;

  contador_fase u_contador (
    .clk       (clk),
    .rst       (rst),
    .reiniciar (cambio),
    .habilitar (1'b1),
    .cuenta    (cuenta)
  );

  assign fuera_rango = ({1'b0, cuenta} < LimInf) || ({1'b0, cuenta} > LimSup);
  // Held phase about to step past the upper limit: catches a stuck lamp early.
  assign excede = seguimiento && medir_q && !cambio && (LimSup < 25'hFFFFFF) &&
                  ({1'b0, cuenta} == LimSup);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      medir_q   <= 1'b0;
      dur_q     <= '0;
      err_dur_q <= 1'b0;
    end else begin
      err_dur_q <= (err_dur_q & ~borrar_errores) | (cambio_legal && medir_q && fuera_rango) |
                   excede;
      if (cambio_legal) begin
        dur_q   <= cuenta;
        medir_q <= 1'b1;
      end else if (!seguimiento || cambio) begin
        medir_q <= 1'b0;
      end
    end
  end

  assign duracion_ultima = dur_q;
  assign error_duracion  = err_dur_q;
`else
  // Timing parameters only matter when duration checking is built in.
  logic unused_param;
  assign unused_param    = ^{DIVISOR, TOLERANCIA};
  assign duracion_ultima = '0;
  assign error_duracion  = 1'b0;
`endif

endmodule
